// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the Amber UART receive deserialiser and the
// transmit serialiser.
//   DATA_BITS    : data bits per character
//   rx_state_e   : receive FSM state encoding
//   even_parity  : even-parity bit over one data byte
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // The bit that makes the total count of ones (data plus parity) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: three-flop synchroniser for the asynchronous RXD pad, plus a
// falling-edge detector on the synchronised value.
// All flops reset to 1, which is the line idle level.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous, active-high reset
//   rxd    in   raw serial input, asynchronous to clk
//   rxd_s  out  synchronised RXD (third stage)
//   fall   out  one cycle high when rxd_s has just gone from 1 to 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic [2:0] sync_r;
  logic       prev_r;

  // Synchroniser chain plus a delayed copy of its output for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 3'b111;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[1:0], rxd};
      prev_r <= sync_r[2];
    end
  end

  assign rxd_s = sync_r[2];
  assign fall  = prev_r & ~sync_r[2];

endmodule

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: receive-side deserialiser for the Amber UART.
// Oversamples RXD, detects the start bit, samples 8 data bits LSB-first at
// mid-bit, checks the stop bit and pushes good bytes over valid/ready.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with parity check;
// without it the framing is 8N1 and o_parity_err is tied low).
// Ports:
//   i_clk, i_rst   clock; asynchronous active-high reset
//   i_uart_rxd     raw serial input (idles high)
//   i_enable       receiver enable; low forces the FSM to IDLE
//   o_rx_data      received byte, stable while o_rx_valid is high
//   o_rx_valid     byte available; i_rx_ready accepts it
//   o_frame_err    pulse: stop bit 0 with non-zero data
//   o_break        pulse: all-zero data and stop bit 0
//   o_overrun      pulse: byte completed while the previous one was not taken
//   o_parity_err   pulse: parity mismatch
//   o_busy         FSM not in IDLE
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 174
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart_rxd,
  input  logic                 i_enable,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMER_ZERO = CNT_W'(0);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rxd_s;
  logic                 rxd_fall;
  rx_state_e            state_r, state_nxt;
  logic [CNT_W-1:0]     timer_r, timer_nxt;
  logic [2:0]           bitcnt_r, bitcnt_nxt;
  logic [DATA_BITS-1:0] shreg_r, shreg_nxt;
  logic                 tick;
  logic                 done_good;
  logic                 ev_frame;
  logic                 ev_break;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_r, par_bad_nxt;
  logic                 ev_parity;
`endif

  uart_rx_sync u_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .rxd   (i_uart_rxd),
    .rxd_s (rxd_s),
    .fall  (rxd_fall)
  );

  assign tick = (timer_r == TIMER_ZERO);

  // Next-state, bit timer, shift register and frame-outcome strobes.
  always_comb begin
    state_nxt  = state_r;
    timer_nxt  = timer_r;
    bitcnt_nxt = bitcnt_r;
    shreg_nxt  = shreg_r;
    done_good  = 1'b0;
    ev_frame   = 1'b0;
    ev_break   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad_r;
    ev_parity   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        timer_nxt  = TIMER_ZERO;
        bitcnt_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = 1'b0;
`endif
        if (rxd_fall && i_enable) begin
          state_nxt = ST_START;
          timer_nxt = HALF_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (!tick) begin
          timer_nxt = timer_r - TIMER_ONE;
        end else if (!rxd_s) begin
          state_nxt  = ST_DATA;
          timer_nxt  = FULL_LOAD;
          bitcnt_nxt = 3'd0;
        end else begin
          // Line back high at mid-start: treat the low as a glitch.
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          timer_nxt = timer_r - TIMER_ONE;
        end else begin
          shreg_nxt = {rxd_s, shreg_r[DATA_BITS-1:1]};
          timer_nxt = FULL_LOAD;
          if (bitcnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bitcnt_nxt = bitcnt_r + 3'd1;
          end
        end
      end
      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (!tick) begin
          timer_nxt = timer_r - TIMER_ONE;
        end else begin
          par_bad_nxt = (rxd_s != even_parity(shreg_r));
          ev_parity   = (rxd_s != even_parity(shreg_r));
          timer_nxt   = FULL_LOAD;
          state_nxt   = ST_STOP;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (!tick) begin
          timer_nxt = timer_r - TIMER_ONE;
        end else if (rxd_s) begin
          state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          done_good = ~par_bad_r;
`else
          done_good = 1'b1;
`endif
        end else if (shreg_r != {DATA_BITS{1'b0}}) begin
          ev_frame  = 1'b1;
          state_nxt = ST_WAIT_HIGH;
        end else begin
          ev_break  = 1'b1;
          state_nxt = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        // Stay out of IDLE until the line returns high so a break or bad
        // stop bit cannot be mistaken for a new start edge.
        timer_nxt = TIMER_ZERO;
        if (rxd_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = TIMER_ZERO;
      end
    endcase

    // Disabling the receiver silently drops whatever frame is in flight.
    if (!i_enable) begin
      state_nxt  = ST_IDLE;
      timer_nxt  = TIMER_ZERO;
      bitcnt_nxt = 3'd0;
      done_good  = 1'b0;
      ev_frame   = 1'b0;
      ev_break   = 1'b0;
`ifdef UART_RX_PARITY_EN
      ev_parity  = 1'b0;
`endif
    end else begin
      state_nxt = state_nxt;
    end
  end

  // FSM state, bit timer, bit counter and shift register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      timer_r  <= TIMER_ZERO;
      bitcnt_r <= 3'd0;
      shreg_r  <= {DATA_BITS{1'b0}};
    end else begin
      state_r  <= state_nxt;
      timer_r  <= timer_nxt;
      bitcnt_r <= bitcnt_nxt;
      shreg_r  <= shreg_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity-failure flag carried from the parity bit to the stop bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      par_bad_r <= 1'b0;
    end else begin
      par_bad_r <= par_bad_nxt;
    end
  end

  // Registered parity-error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_parity_err <= 1'b0;
    end else begin
      o_parity_err <= ev_parity;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

  // Registered push interface, error pulses and busy flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rx_data   <= {DATA_BITS{1'b0}};
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_break     <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_frame_err <= ev_frame;
      o_break     <= ev_break;
      o_busy      <= (state_nxt != ST_IDLE);
      o_overrun   <= 1'b0;
      if (done_good) begin
        // A handshake in the completion cycle frees the holding register.
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_data  <= shreg_r;
          o_rx_valid <= 1'b1;
        end else begin
          o_overrun  <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end else begin
        o_rx_valid <= o_rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
`timescale 1ns/1ps
module tb_uart_rx_deser;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Pad drive -> three synchroniser stages -> start detect, then half a bit to
  // the start sample, the remaining bits, and one cycle for the output register.
  localparam int LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       enable;
  logic       ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       brk;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_uart_rxd   (rxd),
    .i_enable     (enable),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .i_rx_ready   (ready),
    .o_frame_err  (frame_err),
    .o_break      (brk),
    .o_overrun    (overrun),
    .o_parity_err (parity_err),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] acc_q[$];
  int n_frame = 0;
  int n_break = 0;
  int n_over = 0;
  int n_perr = 0;
  int n_valid_hi = 0;
  int first_valid_cyc = -1;
  bit lat_armed = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: inputs change just after posedge, so at negedge valid/ready are
  // exactly what the next posedge will see.
  always @(negedge clk) begin
    if (rx_valid && ready) acc_q.push_back(rx_data);
    if (frame_err) n_frame++;
    if (brk) n_break++;
    if (overrun) n_over++;
    if (parity_err) n_perr++;
    if (rx_valid) n_valid_hi++;
    if (rx_valid && !prev_valid && lat_armed) begin
      first_valid_cyc = cyc;
      lat_armed = 1'b0;
    end
    prev_valid = rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    rxd = 1'b1;
    wait_cycles(3 * CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_good;
    int         exp_frame;
    int         exp_break;
  } vec_t;

  vec_t vecs[8];

  int q0, f0, b0, o0, v0, t0, p0;
  logic [7:0] rdata;
  logic       rstop;
  logic [7:0] exp_q[$];
  int exp_f, exp_b;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 0};
    vecs[2] = '{8'h55, 1'b1, 1, 0, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 0};
    vecs[4] = '{8'h00, 1'b0, 0, 0, 1};
    vecs[5] = '{8'hFF, 1'b0, 0, 1, 0};
    vecs[6] = '{8'h80, 1'b1, 1, 0, 0};
    vecs[7] = '{8'h01, 1'b1, 1, 0, 0};

    rst = 1'b1;
    rxd = 1'b1;
    enable = 1'b1;
    ready = 1'b1;
    wait_cycles(3);
    check("reset_outputs", {18'd0, rx_data, rx_valid, frame_err, brk, overrun, parity_err, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(4);
    check("idle_outputs", {18'd0, rx_data, rx_valid, frame_err, brk, overrun, parity_err, busy}, 32'd0);

    // Latency and single-cycle valid for a good 0xA5 frame.
    q0 = acc_q.size(); v0 = n_valid_hi; f0 = n_frame; b0 = n_break;
    t0 = cyc;
    lat_armed = 1'b1;
    send_frame(8'hA5, 1'b1);
    check("lat_cycles", first_valid_cyc - t0, LAT);
    check("lat_valid_hi_cycles", n_valid_hi - v0, 1);
    check("lat_accepted", acc_q.size() - q0, 1);
    if (acc_q.size() > q0) check("lat_data", acc_q[q0], 8'hA5);
    check("lat_no_err", (n_frame - f0) + (n_break - b0), 0);

    // Table of single frames with ready held high.
    for (int k = 0; k < 8; k++) begin
      q0 = acc_q.size(); f0 = n_frame; b0 = n_break; o0 = n_over;
      send_frame(vecs[k].data, vecs[k].stop);
      check($sformatf("vec%0d_good", k), acc_q.size() - q0, vecs[k].exp_good);
      if (vecs[k].exp_good == 1 && acc_q.size() > q0)
        check($sformatf("vec%0d_data", k), acc_q[$], vecs[k].data);
      check($sformatf("vec%0d_frame", k), n_frame - f0, vecs[k].exp_frame);
      check($sformatf("vec%0d_break", k), n_break - b0, vecs[k].exp_break);
      check($sformatf("vec%0d_overrun", k), n_over - o0, 0);
    end

    // Short low glitch: start sample sees high, nothing reported.
    q0 = acc_q.size(); f0 = n_frame; b0 = n_break;
    rxd = 1'b0;
    wait_cycles(4);
    check("glitch_busy", busy, 1);
    rxd = 1'b1;
    wait_cycles(3 * CPB);
    check("glitch_idle", busy, 0);
    check("glitch_nothing", (acc_q.size() - q0) + (n_frame - f0) + (n_break - b0), 0);

    // Long break: exactly one pulse, then a normal frame.
    q0 = acc_q.size(); b0 = n_break; f0 = n_frame;
    rxd = 1'b0;
    wait_cycles(20 * CPB);
    check("break_held_busy", busy, 1);
    rxd = 1'b1;
    wait_cycles(3 * CPB);
    check("break_pulses", n_break - b0, 1);
    check("break_no_frame", n_frame - f0, 0);
    check("break_no_valid", acc_q.size() - q0, 0);
    send_frame(8'h55, 1'b1);
    check("after_break_rx", acc_q.size() - q0, 1);
    if (acc_q.size() > q0) check("after_break_data", acc_q[$], 8'h55);

    // Overrun: second byte dropped while the first is unclaimed.
    ready = 1'b0;
    q0 = acc_q.size(); o0 = n_over;
    send_frame(8'h11, 1'b1);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1);
    check("ovr_pulse", n_over - o0, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_valid_kept", rx_valid, 1);
    ready = 1'b1;
    wait_cycles(2);
    check("ovr_accept_cnt", acc_q.size() - q0, 1);
    if (acc_q.size() > q0) check("ovr_accept_data", acc_q[$], 8'h11);
    check("ovr_valid_drop", rx_valid, 0);

    // Async reset in the middle of the data bits, with a byte pending.
    ready = 1'b0;
    send_frame(8'h33, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("rst_mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {18'd0, rx_data, rx_valid, frame_err, brk, overrun, parity_err, busy}, 32'd0);
    wait_cycles(2);
    rxd = 1'b1;
    rst = 1'b0;
    ready = 1'b1;
    wait_cycles(2 * CPB);
    check("rst_no_pulse", {29'd0, frame_err, brk, overrun}, 32'd0);
    q0 = acc_q.size(); f0 = n_frame; b0 = n_break;
    send_frame(8'h7E, 1'b1);
    check("rst_then_rx", acc_q.size() - q0, 1);
    if (acc_q.size() > q0) check("rst_then_data", acc_q[$], 8'h7E);
    check("rst_then_no_err", (n_frame - f0) + (n_break - b0), 0);

    // Disable mid-frame: frame dropped silently, receiver usable afterwards.
    q0 = acc_q.size(); f0 = n_frame; b0 = n_break; o0 = n_over;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    enable = 1'b0;
    wait_cycles(1);
    check("dis_idle", busy, 0);
    for (int i = 0; i < 6; i++) drive_bit(i[0]);
    drive_bit(1'b0);
    rxd = 1'b1;
    wait_cycles(3 * CPB);
    enable = 1'b1;
    wait_cycles(2);
    check("dis_nothing", (acc_q.size() - q0) + (n_frame - f0) + (n_break - b0) + (n_over - o0), 0);
    send_frame(8'h5A, 1'b1);
    check("dis_then_rx", acc_q.size() - q0, 1);
    if (acc_q.size() > q0) check("dis_then_data", acc_q[$], 8'h5A);

    // Randomised frames against a frame-level model.
    q0 = acc_q.size(); f0 = n_frame; b0 = n_break; p0 = n_perr;
    exp_f = 0; exp_b = 0;
    for (int k = 0; k < 12; k++) begin
      rdata = 8'($urandom);
      if (k == 3) rdata = 8'h00;
      rstop = ($urandom_range(0, 3) != 0);
      if (rstop) exp_q.push_back(rdata);
      else if (rdata != 8'h00) exp_f++;
      else exp_b++;
      send_frame(rdata, rstop);
    end
    check("rand_count", acc_q.size() - q0, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (q0 + k < acc_q.size())
        check($sformatf("rand_byte%0d", k), acc_q[q0 + k], exp_q[k]);
    end
    check("rand_frame", n_frame - f0, exp_f);
    check("rand_break", n_break - b0, exp_b);
    check("rand_parity", n_perr - p0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
